feature_buffer_ctrl: RTL and testbench
======================================

# feature_buffer_ctrl

Controller for the shared classifier-output BRAM. It captures each feature vector streamed out of the classifier head into one of two ping-pong banks, and arbitrates the single BRAM port between that non-stallable write stream and PS-side readback. It raises an interrupt per committed vector and recycles a bank when the PS releases it. It sits between the classifier output stream and the PS/PL BRAM interface.

## Interface
- DATA_W, 8, BRAM data width
- OFS_W, 9, per-bank offset width; bank depth = 2^OFS_W; BRAM address = {bank, offset}, width OFS_W+1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- valid_in  in  1  stream sample valid; a vector is one contiguous run of valid_in=1
- data_in  in  DATA_W  stream sample
- bram_addr  out  OFS_W+1  BRAM port address
- bram_din  out  DATA_W  BRAM write data
- bram_dout  in  DATA_W  BRAM read data, 1-cycle synchronous read
- bram_en  out  1  port enable
- bram_we  out  1  write enable
- ps_req  in  1  PS read request, level
- ps_addr  in  OFS_W  offset within presented bank
- ps_ack  out  1  combinational: request accepted this cycle
- ps_rdata  out  DATA_W  read data
- ps_rvalid  out  1  read data valid, 1 cycle
- ps_done  in  1  pulse: PS releases presented bank
- vec_ready  out  1  a FULL bank is presented to PS
- rd_bank  out  1  presented bank index
- vec_len  out  OFS_W+1  sample count of presented vector (1..2^OFS_W)
- irq  out  1  1-cycle pulse when a bank becomes presented
- drop_cnt  out  16  dropped-vector counter (see Configuration)

## Operation
- Per-bank state: FREE, FILLING, FULL. Write FSM: IDLE, WRITE, DROP, WAIT_LOW.
- IDLE, valid_in=1: claim lowest-index FREE bank → FILLING, go WRITE, offset counter=0. No FREE bank → DROP, no BRAM writes.
- WRITE: each valid_in=1 cycle writes data_in to {bank, cnt}; cnt increments, saturating at 2^OFS_W; samples past 2^OFS_W are discarded (no write).
- WRITE, valid_in=0: commit. Bank → FULL, length recorded = saturated cnt. FSM → IDLE.
- DROP, valid_in=0: drop_cnt +1 (saturating at 0xFFFF); FSM → IDLE.
- Presentation: FULL banks are presented in commit order. When vec_ready=0 and a FULL bank exists, present it: set rd_bank, vec_len, vec_ready=1, pulse irq.
- ps_done while vec_ready=1: presented bank → FREE, vec_ready=0. If the other bank is FULL, present it the next cycle with an irq pulse. ps_done while vec_ready=0 is ignored.
- Arbitration: write has absolute priority. ps_ack = ps_req & vec_ready & ~valid_in & ~rst. Every acked cycle issues one read; back-to-back reads are allowed. ps_addr ≥ vec_len is still read and returns stale data.
- Commit and ps_done in the same cycle: both take effect; the newly FULL bank is presented next cycle.
- Reset: all banks FREE. The FSM enters WAIT_LOW and moves to IDLE only after valid_in=0, so a partial vector in flight is never captured.
- Reset values: bram_addr=0, bram_din=0, bram_en=0, bram_we=0, ps_rdata=0, ps_rvalid=0, vec_ready=0, rd_bank=0, vec_len=0, irq=0, drop_cnt=0.

## Timing
- Write: valid_in sampled in cycle t → bram_en=bram_we=1 with addr/din valid in cycle t+1.
- Commit: first valid_in=0 cycle t → bank FULL at t+1. Presentation (vec_ready, irq) at t+2 if nothing is presented.
- Read: ps_ack in cycle t → bram_addr={rd_bank,ps_addr}, en=1, we=0 in t+1 → ps_rvalid=1 with ps_rdata in t+3.
- bram_en=0 in idle cycles.

## Configuration
- FEATBUF_DROP_CNT_EN defined: the drop counter is implemented as described.
- FEATBUF_DROP_CNT_EN undefined: no counter logic; drop_cnt is constant 0. Dropping behaviour itself is unchanged.

## Test plan
- 10-sample vector 0x01..0x0A after reset → writes to addr 0..9 at t+1 each; irq at t+2 after valid_in falls; vec_len=10, rd_bank=0.
- PS reads offsets 0..9 back-to-back → ps_ack each cycle; ps_rvalid 3 cycles later with data 0x01..0x0A in order.
- Three vectors with no ps_done → banks 0 and 1 FULL; third produces no BRAM writes; drop_cnt=1 (0 without macro).
- ps_done with bank 1 FULL → vec_ready drops one cycle, then rd_bank=1 with irq pulse.
- ps_req held while a 5-sample vector streams → ps_ack=0 for all 5 valid_in cycles, resumes the next cycle.
- 600-sample vector (OFS_W=9) → exactly 512 writes, vec_len=512. rst asserted mid-vector with valid_in held → no writes until valid_in low then high again.

Source files
------------

// File: rtl/feature_buffer_ctrl.sv
// feature_buffer_ctrl: ping-pong capture of classifier vectors into a shared BRAM with PS readback arbitration.
// Define FEATBUF_DROP_CNT_EN to implement the dropped-vector counter; otherwise drop_cnt is tied to 0.
module feature_buffer_ctrl #(
  parameter int DATA_W = 8,
  parameter int OFS_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [OFS_W:0]    bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              bram_en,
  output logic              bram_we,
  input  logic              ps_req,
  input  logic [OFS_W-1:0]  ps_addr,
  output logic              ps_ack,
  output logic [DATA_W-1:0] ps_rdata,
  output logic              ps_rvalid,
  input  logic              ps_done,
  output logic              vec_ready,
  output logic              rd_bank,
  output logic [OFS_W:0]    vec_len,
  output logic              irq,
  output logic [15:0]       drop_cnt
);
  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bank_t;
  typedef enum logic [1:0] {IDLE, WRITE, DROP, WAIT_LOW} wst_t;
  localparam logic [OFS_W:0] DEPTH = {1'b1, {OFS_W{1'b0}}};
  wst_t st;
  bank_t bs [2];
  logic [OFS_W:0] len [2];
  logic [OFS_W:0] cnt;
  logic wb, last_c, rd_p1, rd_p2;
  logic [1:0] full;
  logic any_free, free_b, pres_b;
  assign full = {bs[1] == B_FULL, bs[0] == B_FULL};
  assign any_free = bs[0] == B_FREE || bs[1] == B_FREE;
  assign free_b = bs[0] != B_FREE;
  // With both banks waiting, the older commit goes first.
  assign pres_b = &full ? ~last_c : full[1];
  assign ps_ack = ps_req & vec_ready & ~valid_in & ~rst;
`ifndef FEATBUF_DROP_CNT_EN
  assign drop_cnt = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= WAIT_LOW;
      bs[0] <= B_FREE;
      bs[1] <= B_FREE;
      len[0] <= '0;
      len[1] <= '0;
      cnt <= '0;
      wb <= 1'b0;
      last_c <= 1'b0;
      rd_p1 <= 1'b0;
      rd_p2 <= 1'b0;
      bram_addr <= '0;
      bram_din <= '0;
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      ps_rdata <= '0;
      ps_rvalid <= 1'b0;
      vec_ready <= 1'b0;
      rd_bank <= 1'b0;
      vec_len <= '0;
      irq <= 1'b0;
`ifdef FEATBUF_DROP_CNT_EN
      drop_cnt <= '0;
`endif
    end else begin
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      irq <= 1'b0;
      rd_p1 <= ps_ack;
      rd_p2 <= rd_p1;
      ps_rvalid <= rd_p2;
      if (rd_p2) ps_rdata <= bram_dout;
      if (ps_ack) begin
        bram_en <= 1'b1;
        bram_addr <= {rd_bank, ps_addr};
      end
      case (st)
        IDLE: if (valid_in) begin
          if (any_free) begin
            bs[free_b] <= B_FILL;
            wb <= free_b;
            cnt <= 1;
            bram_en <= 1'b1;
            bram_we <= 1'b1;
            bram_addr <= {free_b, {OFS_W{1'b0}}};
            bram_din <= data_in;
            st <= WRITE;
          end else st <= DROP;
        end
        WRITE: if (valid_in) begin
          if (cnt != DEPTH) begin
            bram_en <= 1'b1;
            bram_we <= 1'b1;
            bram_addr <= {wb, cnt[OFS_W-1:0]};
            bram_din <= data_in;
            cnt <= cnt + 1'b1;
          end
        end else begin
          bs[wb] <= B_FULL;
          len[wb] <= cnt;
          last_c <= wb;
          st <= IDLE;
        end
        DROP: if (!valid_in) begin
`ifdef FEATBUF_DROP_CNT_EN
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
          st <= IDLE;
        end
        default: if (!valid_in) st <= IDLE;
      endcase
      if (vec_ready && ps_done) begin
        bs[rd_bank] <= B_FREE;
        vec_ready <= 1'b0;
      end else if (!vec_ready && |full) begin
        vec_ready <= 1'b1;
        rd_bank <= pres_b;
        vec_len <= len[pres_b];
        irq <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_feature_buffer_ctrl.sv
// tb_feature_buffer_ctrl: table-driven, directed and randomized checks of feature_buffer_ctrl.
module tb_feature_buffer_ctrl;
  localparam int DW = 8;
  localparam int OW = 9;
  localparam int NR = 4000;
`ifdef FEATBUF_DROP_CNT_EN
  localparam int DROP_EN = 1;
`else
  localparam int DROP_EN = 0;
`endif
  logic clk = 0, rst = 1, valid_in = 0, ps_req = 0, ps_done = 0;
  logic [DW-1:0] data_in = 0, bram_din, bram_dout = 0, ps_rdata;
  logic [OW:0] bram_addr, vec_len;
  logic [OW-1:0] ps_addr = 0;
  logic bram_en, bram_we, ps_ack, ps_rvalid, vec_ready, rd_bank, irq;
  logic [15:0] drop_cnt;
  logic [DW-1:0] mem [1 << (OW + 1)];
  int checks = 0, errors = 0;

  typedef struct {
    logic v;
    logic [7:0] d;
    logic en;
    logic [9:0] addr;
    logic [7:0] din;
    logic irq;
    logic vr;
  } tvec_t;
  tvec_t tbl [15];

  typedef struct packed {
    logic b;
    logic [4:0] len;
    logic [15:0][7:0] d;
  } vrec_t;
  typedef struct packed {
    logic [31:0] due;
    logic [7:0] d;
  } pend_t;
  vrec_t q[$];
  vrec_t cur;
  pend_t pend[$];
  logic [1:0] held;
  logic prev_vr, pdone, cur_drop, in_vec, busy;
  int rem, gap, drops, k_ps, wait_c, n, we_a, we_b;

  feature_buffer_ctrl #(.DATA_W(DW), .OFS_W(OW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout),
    .bram_en(bram_en), .bram_we(bram_we), .ps_req(ps_req), .ps_addr(ps_addr),
    .ps_ack(ps_ack), .ps_rdata(ps_rdata), .ps_rvalid(ps_rvalid), .ps_done(ps_done),
    .vec_ready(vec_ready), .rd_bank(rd_bank), .vec_len(vec_len), .irq(irq),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else bram_dout <= mem[bram_addr];
    end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int c = 0; c < 15; c++) begin
      tbl[c].v = c >= 1 && c <= 10;
      tbl[c].d = 8'(c);
      tbl[c].en = c >= 2 && c <= 11;
      tbl[c].addr = 10'(c - 2);
      tbl[c].din = 8'(c - 1);
      tbl[c].irq = c == 13;
      tbl[c].vr = c >= 13;
    end
    repeat (2) @(posedge clk);
    #1;
    ps_req = 1;
    #2;
    chk("reset_outputs", {bram_en, bram_we, bram_addr, bram_din, ps_rdata, ps_rvalid,
        vec_ready, rd_bank, vec_len, irq, drop_cnt, ps_ack}, 0);
    ps_req = 0;
    rst = 0;
    tick;
    // 10-sample vector written then presented
    for (int c = 0; c < 15; c++) begin
      valid_in = tbl[c].v;
      data_in = tbl[c].d;
      #2;
      chk("tbl_en", bram_en, tbl[c].en);
      chk("tbl_we", bram_we, tbl[c].en);
      if (tbl[c].en) begin
        chk("tbl_addr", bram_addr, tbl[c].addr);
        chk("tbl_din", bram_din, tbl[c].din);
      end
      chk("tbl_irq", irq, tbl[c].irq);
      chk("tbl_vec_ready", vec_ready, tbl[c].vr);
      chk("tbl_ack", ps_ack, 0);
      tick;
    end
    chk("vec_len_10", vec_len, 10);
    chk("rd_bank_0", rd_bank, 0);
    // back-to-back PS reads
    for (int j = 0; j < 14; j++) begin
      ps_req = j < 10;
      ps_addr = OW'(j);
      #2;
      chk("rd_ack", ps_ack, j < 10);
      if (j >= 1 && j <= 10) begin
        chk("rd_en", bram_en, 1);
        chk("rd_we", bram_we, 0);
        chk("rd_addr", bram_addr, j - 1);
      end
      chk("rd_rvalid", ps_rvalid, j >= 3 && j <= 12);
      if (j >= 3 && j <= 12) chk("rd_data", ps_rdata, j - 2);
      tick;
    end
    ps_req = 0;
    // second vector with PS request held: writes win
    ps_req = 1;
    ps_addr = 0;
    for (int k = 0; k < 6; k++) begin
      valid_in = k < 5;
      data_in = 8'(8'h20 + k);
      #2;
      chk("hold_ack", ps_ack, k == 5);
      if (k >= 1) begin
        chk("v2_we", bram_we, 1);
        chk("v2_addr", bram_addr, 10'h200 + 10'(k - 1));
        chk("v2_din", bram_din, 8'h20 + k - 1);
      end
      tick;
    end
    ps_req = 0;
    repeat (3) tick;
    // third vector with both banks full is dropped
    we_a = 0;
    for (int k = 0; k < 10; k++) begin
      valid_in = k < 4;
      data_in = 8'h40;
      #2;
      we_a += int'(bram_we);
      tick;
    end
    chk("drop_no_writes", we_a, 0);
    chk("drop_cnt_1", drop_cnt, DROP_EN);
    chk("drop_vr", {vec_ready, rd_bank}, 2'b10);
    // release bank 0, bank 1 follows
    for (int j = 0; j < 7; j++) begin
      ps_done = j == 0;
      ps_req = j == 3;
      ps_addr = 2;
      #2;
      chk("done_vr", vec_ready, j != 1);
      chk("done_irq", irq, j == 2);
      if (j == 2) chk("done_bank_len", {rd_bank, vec_len}, {1'b1, 10'd5});
      if (j == 3) chk("done_ack", ps_ack, 1);
      if (j == 6) chk("done_read", {ps_rvalid, ps_rdata}, {1'b1, 8'h22});
      tick;
    end
    ps_req = 0;
    ps_done = 1;
    tick;
    ps_done = 0;
    tick;
    #2;
    chk("free_vr", vec_ready, 0);
    tick;
    // 600-sample vector saturates at 512
    we_a = 0;
    for (int k = 0; k < 605; k++) begin
      valid_in = k < 600;
      data_in = k >= 512 ? 8'hEE : 8'(k);
      #2;
      we_a += int'(bram_we);
      tick;
    end
    chk("sat_writes", we_a, 512);
    chk("sat_present", {vec_ready, rd_bank, vec_len}, {1'b1, 1'b0, 10'd512});
    ps_req = 1;
    ps_addr = 0;
    #2;
    chk("sat_ack", ps_ack, 1);
    tick;
    ps_req = 0;
    tick;
    tick;
    #2;
    chk("sat_read0", {ps_rvalid, ps_rdata}, {1'b1, 8'h00});
    tick;
    ps_done = 1;
    tick;
    ps_done = 0;
    tick;
    // reset mid-vector with valid_in held high
    we_a = 0;
    we_b = 0;
    for (int k = 0; k < 16; k++) begin
      rst = k == 3;
      valid_in = k <= 8 || (k >= 10 && k <= 12);
      data_in = 8'(8'h60 + k);
      #2;
      if (k == 4) chk("rst_clear", {bram_en, vec_ready, rd_bank, drop_cnt}, 0);
      if (k >= 4 && k <= 10) we_a += int'(bram_we);
      if (k >= 11) we_b += int'(bram_we);
      if (k == 11) chk("rst_first_wr", {bram_we, bram_addr, bram_din}, {1'b1, 10'd0, 8'h6A});
      tick;
    end
    chk("rst_no_writes", we_a, 0);
    chk("rst_new_writes", we_b, 3);
    chk("rst_vec_len", {vec_ready, vec_len}, {1'b1, 10'd3});
    // randomized traffic against a transaction-level model
    rst = 1;
    valid_in = 0;
    tick;
    tick;
    rst = 0;
    held = 0;
    prev_vr = 0;
    busy = 0;
    in_vec = 0;
    rem = 0;
    gap = 1;
    drops = 0;
    k_ps = 0;
    wait_c = 0;
    cur = '0;
    cur_drop = 0;
    for (int cyc = 0; cyc < NR + 400; cyc++) begin
      ps_done = 0;
      ps_req = 0;
      pdone = 0;
      if (busy) begin
        if (wait_c > 0) wait_c--;
        else if (k_ps == int'(q[0].len) && pend.size() == 0) begin
          ps_done = 1;
          pdone = 1;
          held[q[0].b] = 0;
          void'(q.pop_front());
          busy = 0;
        end else if (k_ps < int'(q[0].len)) begin
          ps_req = $urandom_range(3) != 0;
          ps_addr = OW'(k_ps);
        end
      end
      if (rem > 0) begin
        valid_in = 1;
        data_in = 8'($urandom);
        if (!cur_drop) begin
          cur.d[cur.len] = data_in;
          cur.len = cur.len + 1;
        end
        rem--;
      end else if (in_vec) begin
        valid_in = 0;
        in_vec = 0;
        if (!cur_drop) q.push_back(cur);
        gap = $urandom_range(3);
      end else if (gap > 0) begin
        valid_in = 0;
        gap--;
      end else if (cyc < NR && !pdone && $urandom_range(2) == 0) begin
        n = $urandom_range(12, 1);
        valid_in = 1;
        data_in = 8'($urandom);
        in_vec = 1;
        rem = n - 1;
        cur_drop = held[0] && held[1];
        if (cur_drop) drops++;
        else begin
          cur = '0;
          cur.b = held[0];
          held[cur.b] = 1;
          cur.len = 1;
          cur.d[0] = data_in;
        end
      end else valid_in = 0;
      #2;
      chk("rnd_ack", ps_ack, ps_req & vec_ready & ~valid_in);
      if (ps_ack) begin
        pend.push_back('{32'(cyc + 3), q[0].d[ps_addr]});
        k_ps++;
      end
      if (pend.size() > 0 && int'(pend[0].due) == cyc) begin
        chk("rnd_rvalid", ps_rvalid, 1);
        chk("rnd_rdata", ps_rdata, pend[0].d);
        void'(pend.pop_front());
      end else chk("rnd_rvalid", ps_rvalid, 0);
      chk("rnd_irq", irq, vec_ready && !prev_vr);
      prev_vr = vec_ready;
      if (!busy && !pdone && vec_ready) begin
        if (q.size() == 0) chk("rnd_spurious_present", vec_ready, 0);
        else begin
          chk("rnd_present", {rd_bank, vec_len}, {q[0].b, 5'd0, q[0].len});
          busy = 1;
          k_ps = 0;
          wait_c = $urandom_range(24);
        end
      end
      tick;
    end
    chk("rnd_drained", {28'(q.size()), busy, in_vec}, 0);
    chk("rnd_drop_cnt", drop_cnt, DROP_EN != 0 ? drops : 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
